// File: rtl/uart_peripheral.sv
// uart_peripheral: memory-mapped 8N1 UART; bus ack one cycle after any request, reads registered.
// No backpressure: TX writes while busy or disabled are dropped, an RX byte arriving while full sets overrun.
module uart_peripheral #(
  parameter logic [15:0] DEFAULT_DIVIDER = 16'd434,
  parameter int          ADDR_WIDTH      = 4
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  bus_valid,
  input  logic                  bus_write,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  output logic                  bus_ready,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  uart_irq
);

  localparam int AW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        enable_q, enable_d;
  logic [15:0] divider_q, divider_d;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic        tx_busy_q, tx_busy_d;
  logic        tx_out_q, tx_out_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_avail_q, rx_avail_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        rx_ferr_q, rx_ferr_d;

  logic [AW-1:0] word;
  logic          is_cfg, is_status, is_rxd, is_txd;
  logic          accept, wr, rd, load_ok, line;
  logic [15:0]   eff_div;
  logic          unused_ok;

  assign word      = bus_addr[ADDR_WIDTH-1:2];
  assign is_cfg    = (word == AW'(0));
  assign is_status = (word == AW'(1));
  assign is_rxd    = (word == AW'(2));
  assign is_txd    = (word == AW'(3));
  assign accept    = bus_valid & ~ready_q;
  assign wr        = accept & bus_write;
  assign rd        = accept & ~bus_write;
  assign eff_div   = (divider_q < 16'd4) ? 16'd4 : divider_q;
  assign line      = rx_s2_q;
  // A read ack frees the holding register in the same cycle a new byte may land.
  assign load_ok   = ~rx_avail_q | (rd & is_rxd);
  assign unused_ok = ^{bus_wdata[31:17], bus_addr[1:0]};

  always_comb begin
    ready_d    = accept;
    rdata_d    = '0;
    enable_d   = enable_q;
    divider_d  = divider_q;
    rx_s1_d    = uart_rx;
    rx_s2_d    = rx_s1_q;
    tx_busy_d  = tx_busy_q;
    tx_out_d   = tx_out_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_avail_d = rx_avail_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;

    if (rd) begin
      if (is_cfg)    rdata_d = {15'b0, enable_q, divider_q};
      if (is_status) rdata_d = {28'b0, rx_ferr_q, rx_ovr_q, tx_busy_q, rx_avail_q};
      if (is_rxd) begin
        rdata_d    = {24'b0, rx_data_q};
        rx_avail_d = 1'b0;
      end
    end
    if (wr && is_cfg) begin
      enable_d  = bus_wdata[16];
      divider_d = bus_wdata[15:0];
    end
    if (wr && is_status) begin
      rx_ovr_d  = rx_ovr_q & ~bus_wdata[2];
      rx_ferr_d = rx_ferr_q & ~bus_wdata[3];
    end

    // Bit period is re-latched at each boundary so divider writes apply to the next bit.
    if (!enable_q) begin
      tx_busy_d = 1'b0;
      tx_out_d  = 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == tx_div_q - 16'd1) begin
        tx_cnt_d = '0;
        tx_div_d = eff_div;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_out_d  = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          tx_out_d = (tx_bit_q == 4'd8) ? 1'b1 : tx_byte_q[tx_bit_q[2:0]];
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 16'd1;
      end
    end else if (wr && is_txd) begin
      tx_busy_d = 1'b1;
      tx_out_d  = 1'b0;
      tx_cnt_d  = '0;
      tx_bit_d  = '0;
      tx_div_d  = eff_div;
      tx_byte_d = bus_wdata[7:0];
    end

    if (!enable_q) begin
      rx_state_d = RX_IDLE;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!line) begin
            rx_state_d = RX_START;
            rx_cnt_d   = '0;
            rx_div_d   = eff_div;
          end
        end
        RX_START: begin
          if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
            rx_cnt_d = '0;
            rx_div_d = eff_div;
            rx_bit_d = '0;
            rx_state_d = line ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_cnt_d   = '0;
            rx_div_d   = eff_div;
            rx_shift_d = {line, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_state_d = RX_IDLE;
            rx_cnt_d   = '0;
            // Set events are applied after W1C so a coinciding clear loses.
            if (load_ok) begin
              rx_data_d  = rx_shift_q;
              rx_avail_d = 1'b1;
            end else begin
              rx_ovr_d = 1'b1;
            end
            if (!line) rx_ferr_d = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      enable_q   <= 1'b0;
      divider_q  <= DEFAULT_DIVIDER;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_cnt_q   <= '0;
      tx_div_q   <= 16'd4;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= 16'd4;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_avail_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      enable_q   <= enable_d;
      divider_q  <= divider_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      tx_busy_q  <= tx_busy_d;
      tx_out_q   <= tx_out_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_avail_q <= rx_avail_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;
  assign uart_tx   = tx_out_q;
  assign uart_irq  = rx_avail_q | rx_ovr_q;

endmodule

// File: tb/tb_uart_peripheral.sv
// Bench for uart_peripheral: bus-level stimulus with a flag/holding-register model of the receiver.
module tb_uart_peripheral;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_write = 1'b0;
  logic [3:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        uart_rx;
  logic        uart_tx;
  logic        uart_irq;
  logic        rx_drv = 1'b1;
  logic        loopback = 1'b0;

  int errors = 0;
  int checks = 0;

  logic       m_avail, m_ovr, m_ferr;
  logic [7:0] m_data;

  localparam logic [3:0] A_CFG = 4'h0, A_STAT = 4'h4, A_RXD = 4'h8, A_TXD = 4'hC;

  assign uart_rx = loopback ? uart_tx : rx_drv;

  always #5 clock = ~clock;

  uart_peripheral dut (
    .clock(clock), .resetb(resetb),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_irq(uart_irq)
  );

  function automatic logic [31:0] m_status();
    return {28'b0, m_ferr, m_ovr, 1'b0, m_avail};
  endfunction

  // Receiver rules: first byte is held, later ones overrun until read.
  task automatic model_rx(input logic [7:0] b, input logic stp);
    if (!m_avail) begin
      m_data  = b;
      m_avail = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
    if (!stp) m_ferr = 1'b1;
  endtask

  task automatic model_reset();
    m_avail = 0; m_ovr = 0; m_ferr = 0; m_data = '0;
  endtask

  task automatic bus_op(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdv);
    int n;
    @(negedge clock);
    bus_valid = 1'b1; bus_write = wr; bus_addr = addr; bus_wdata = wd;
    @(negedge clock);
    n = 1;
    while (!bus_ready && n < 8) begin
      @(negedge clock);
      n++;
    end
    if (!bus_ready) begin
      checks++; errors++;
      $display("FAIL bus_timeout: addr %h ready %b required 1", addr, bus_ready);
    end
    rdv = bus_rdata;
    bus_valid = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_op(1'b1, addr, wd, dummy);
  endtask

  task automatic rd_reg(input logic [3:0] addr, output logic [31:0] rdv);
    bus_op(1'b0, addr, 32'h0, rdv);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stp, input int div);
    for (int i = 0; i < 10; i++) begin
      rx_drv = (i == 0) ? 1'b0 : (i == 9) ? stp : b[i-1];
      repeat (div) @(negedge clock);
    end
    rx_drv = 1'b1;
    repeat (3 * div) @(negedge clock);
  endtask

  task automatic capture_tx(input int div, output logic [7:0] b, output logic stp, output logic ok);
    int n;
    n = 0;
    ok = 1'b1;
    b = '0;
    stp = 1'b0;
    while (uart_tx !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (uart_tx !== 1'b0) begin
      ok = 1'b0;
    end else begin
      repeat (div / 2) @(negedge clock);
      if (uart_tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (div) @(negedge clock);
        b[i] = uart_tx;
      end
      repeat (div) @(negedge clock);
      stp = uart_tx;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    resetb = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus_ready); end
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus_rdata); end
    checks++; if (uart_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", uart_irq); end
    resetb = 1'b1;
    rd_reg(A_CFG, r);
    checks++; if (r !== 32'h000001B2) begin errors++; $display("FAIL reset_config: got %h want 000001b2", r); end
    rd_reg(A_STAT, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", r); end
  endtask

  task automatic test_tx_basic();
    logic [9:0]  frame;
    logic [31:0] r;
    int bad, seen_low;
    frame = {1'b1, 8'h55, 1'b0};
    bad = 0;
    wr_reg(A_CFG, 32'h00010004);
    wr_reg(A_TXD, 32'h55);
    fork
      begin
        for (int k = 0; k <= 40; k++) begin
          if (k > 0) @(negedge clock);
          checks++;
          if (uart_tx !== ((k < 40) ? frame[k/4] : 1'b1)) begin
            errors++;
            $display("FAIL tx55_bit k=%0d: got %b want %b", k, uart_tx, (k < 40) ? frame[k/4] : 1'b1);
          end
        end
      end
      begin
        repeat (10) @(negedge clock);
        rd_reg(A_STAT, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL tx_busy_mid: got %h want 2", r); end
        wr_reg(A_TXD, 32'hFF);
      end
    join
    seen_low = 0;
    repeat (30) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) seen_low = 1;
    end
    checks++; if (seen_low != 0) begin errors++; $display("FAIL tx_drop_busy: line went low, required idle"); end
    rd_reg(A_STAT, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL tx_busy_end: got %h want 0", r); end
  endtask

  task automatic test_tx_random();
    logic [7:0]  b, got;
    logic [15:0] raw;
    logic        stp, ok;
    int          div;
    for (int it = 0; it < 5; it++) begin
      raw = (it == 0) ? 16'd1 : 16'($urandom_range(4, 12));
      div = (raw < 16'd4) ? 4 : int'(raw);
      b = 8'($urandom);
      wr_reg(A_CFG, {15'b0, 1'b1, raw});
      fork
        capture_tx(div, got, stp, ok);
        wr_reg(A_TXD, {24'b0, b});
      join
      repeat (div) @(negedge clock);
      checks++;
      if (!ok || got !== b || stp !== 1'b1) begin
        errors++;
        $display("FAIL tx_rand div=%0d: got %h stop %b ok %b want %h stop 1", div, got, stp, ok, b);
      end
    end
  endtask

  task automatic test_loopback();
    logic [31:0] r;
    logic [7:0]  b;
    loopback = 1'b1;
    wr_reg(A_CFG, 32'h00010004);
    for (int it = 0; it < 4; it++) begin
      b = (it == 0) ? 8'hA3 : 8'($urandom);
      wr_reg(A_TXD, {24'b0, b});
      repeat (60) @(negedge clock);
      model_rx(b, 1'b1);
      rd_reg(A_STAT, r);
      checks++; if (r !== m_status()) begin errors++; $display("FAIL loop_status: got %h want %h", r, m_status()); end
      checks++; if (uart_irq !== 1'b1) begin errors++; $display("FAIL loop_irq_set: got %b want 1", uart_irq); end
      rd_reg(A_RXD, r);
      checks++; if (r !== {24'b0, m_data}) begin errors++; $display("FAIL loop_data: got %h want %h", r, m_data); end
      m_avail = 1'b0;
      rd_reg(A_STAT, r);
      checks++; if (r !== m_status()) begin errors++; $display("FAIL loop_status_clr: got %h want %h", r, m_status()); end
      checks++; if (uart_irq !== 1'b0) begin errors++; $display("FAIL loop_irq_clr: got %b want 0", uart_irq); end
    end
    loopback = 1'b0;
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    wr_reg(A_CFG, 32'h00010008);
    drive_rx(8'h12, 1'b1, 8); model_rx(8'h12, 1'b1);
    drive_rx(8'h34, 1'b1, 8); model_rx(8'h34, 1'b1);
    rd_reg(A_STAT, r);
    checks++; if (r !== 32'h5) begin errors++; $display("FAIL ovr_status: got %h want 5", r); end
    wr_reg(A_STAT, 32'h4);
    m_ovr = 1'b0;
    rd_reg(A_STAT, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL ovr_w1c: got %h want 1", r); end
    rd_reg(A_RXD, r);
    checks++; if (r !== 32'h12) begin errors++; $display("FAIL ovr_data: got %h want 12", r); end
    m_avail = 1'b0;
    rd_reg(A_RXD, r);
    checks++; if (r !== 32'h12) begin errors++; $display("FAIL empty_read: got %h want 12", r); end
    rd_reg(A_STAT, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL empty_status: got %h want 0", r); end
  endtask

  task automatic test_frame_error();
    logic [31:0] r;
    drive_rx(8'h7E, 1'b0, 8); model_rx(8'h7E, 1'b0);
    rd_reg(A_STAT, r);
    checks++; if (r !== 32'h9) begin errors++; $display("FAIL ferr_status: got %h want 9", r); end
    rd_reg(A_RXD, r);
    checks++; if (r !== 32'h7E) begin errors++; $display("FAIL ferr_data: got %h want 7e", r); end
    m_avail = 1'b0;
    wr_reg(A_STAT, 32'h8);
    m_ferr = 1'b0;
    @(negedge clock); rx_drv = 1'b0;
    @(negedge clock); rx_drv = 1'b1;
    repeat (120) @(negedge clock);
    rd_reg(A_STAT, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL glitch_status: got %h want 0", r); end
  endtask

  task automatic test_random_rx();
    logic [31:0] r;
    logic [7:0]  b;
    logic [3:0]  w;
    logic        stp;
    int          div;
    div = $urandom_range(4, 10);
    wr_reg(A_CFG, {15'b0, 1'b1, 16'(div)});
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          b = 8'($urandom);
          stp = ($urandom_range(0, 3) != 0);
          drive_rx(b, stp, div);
          model_rx(b, stp);
        end
        2: begin
          rd_reg(A_RXD, r);
          checks++; if (r !== {24'b0, m_data}) begin errors++; $display("FAIL rand_data: got %h want %h", r, m_data); end
          m_avail = 1'b0;
        end
        default: begin
          w = 4'($urandom);
          wr_reg(A_STAT, {28'b0, w});
          if (w[2]) m_ovr = 1'b0;
          if (w[3]) m_ferr = 1'b0;
        end
      endcase
      rd_reg(A_STAT, r);
      checks++; if (r !== m_status()) begin errors++; $display("FAIL rand_status it=%0d: got %h want %h", it, r, m_status()); end
      checks++; if (uart_irq !== (m_avail | m_ovr)) begin errors++; $display("FAIL rand_irq: got %b want %b", uart_irq, m_avail | m_ovr); end
    end
  endtask

  task automatic test_enable_abort();
    logic [31:0] r;
    int seen_low;
    wr_reg(A_CFG, 32'h00010010);
    wr_reg(A_TXD, 32'h00);
    repeat (20) @(negedge clock);
    wr_reg(A_CFG, 32'h00000010);
    repeat (2) @(negedge clock);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b want 1", uart_tx); end
    rd_reg(A_STAT, r);
    checks++; if (r !== m_status()) begin errors++; $display("FAIL abort_status: got %h want %h", r, m_status()); end
    wr_reg(A_TXD, 32'h00);
    seen_low = 0;
    repeat (40) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) seen_low = 1;
    end
    checks++; if (seen_low != 0) begin errors++; $display("FAIL tx_drop_disabled: line went low, required idle"); end
    rd_reg(A_CFG, r);
    checks++; if (r !== 32'h10) begin errors++; $display("FAIL abort_config: got %h want 10", r); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] r;
    wr_reg(A_CFG, 32'h00010004);
    wr_reg(A_TXD, 32'h00);
    repeat (6) @(negedge clock);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midtx_low: got %b want 0", uart_tx); end
    #2 resetb = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b want 1", uart_tx); end
    model_reset();
    @(negedge clock);
    resetb = 1'b1;
    rd_reg(A_CFG, r);
    checks++; if (r !== 32'h000001B2) begin errors++; $display("FAIL midtx_config: got %h want 000001b2", r); end
    rd_reg(A_STAT, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL midtx_status: got %h want 0", r); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_random();
    test_loopback();
    test_overrun();
    test_frame_error();
    test_random_rx();
    test_enable_abort();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
